sda_multi_kernel_reset_handler: RTL and testbench

// Per-kernel reset and go/done sequencer for a wrapper hosting NumKernels

---
 rtl/sda_multi_kernel_reset_handler.sv | 189 ++++++++++++++++++
 tb/tb_sda_multi_kernel_reset_handler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sda_multi_kernel_reset_handler.sv
// Per-kernel reset and go/done sequencer for a wrapper hosting several
// independent kernels. Each channel holds its kernel in reset between runs,
// releases it on a register-block go and forwards the go once the kernel reset
// has drained. It then waits for done, reports it back, and records the run
// length. A per-channel abort returns a running channel to its reset timeout.
module sda_multi_kernel_reset_handler #(
  parameter int NumKernels      = 4,
  parameter int ResetCountSize  = 5,
  parameter int ResetPipeLength = 8,
  parameter int CycleCountWidth = 32
) (
  input  logic                                  clk,
  input  logic                                  sysRstReq,
  input  logic [NumKernels-1:0]                 regGoValid,
  output logic [NumKernels-1:0]                 regGoHoldoff,
  output logic [NumKernels-1:0]                 regDoneValid,
  input  logic [NumKernels-1:0]                 regDoneStop,
  input  logic [NumKernels-1:0]                 regAbort,
  output logic [NumKernels*CycleCountWidth-1:0] regRunCycles,
  output logic [NumKernels-1:0]                 kernelGoValid,
  input  logic [NumKernels-1:0]                 kernelGoHoldoff,
  input  logic [NumKernels-1:0]                 kernelDoneValid,
  output logic [NumKernels-1:0]                 kernelDoneStop,
  output logic                                  wrapperReset,
  output logic [NumKernels-1:0]                 kernelReset
);

  typedef enum logic [2:0] {
    ResetTimeout   = 3'd0,
    ResetIdle      = 3'd1,
    KernelStarting = 3'd2,
    KernelRunning  = 3'd3,
    KernelExited   = 3'd4
  } chanState_t;

  // Bitstream-initialised so the first clocks after load produce one reset cycle.
  logic enabledQ = 1'b0;
  logic rstQ     = 1'b1;
  logic [ResetPipeLength-1:0] wrapperPipeQ;

  // Internal reset: external request, or the first cycle after configuration.
  always_ff @(posedge clk) begin
    enabledQ <= 1'b1;
    rstQ     <= sysRstReq | ~enabledQ;
  end

  // Wrapper reset pipeline: loads ones while asserted, drains zeros toward bit 0.
  always_ff @(posedge clk) begin
    if (rstQ) wrapperPipeQ <= '1;
    else      wrapperPipeQ <= wrapperPipeQ >> 1;
  end

  assign wrapperReset = wrapperPipeQ[0];

  for (genvar i = 0; i < NumKernels; i++) begin : gChan
    chanState_t                 stateQ, stateD;
    logic [ResetCountSize-1:0]  countQ, countD;
    logic [CycleCountWidth-1:0] runQ, runD;
    logic [ResetPipeLength-1:0] pipeQ;
    logic kResetQ, kResetD;
    logic goHoldoffQ, goHoldoffD;
    logic doneValidQ, doneValidD;
    logic kGoValidQ, kGoValidD;
    logic kDoneStopQ, kDoneStopD;

    // Next-state and registered-output logic for one channel.
    always_comb begin
      stateD     = stateQ;
      countD     = countQ;
      runD       = runQ;
      kResetD    = kResetQ;
      goHoldoffD = goHoldoffQ;
      doneValidD = doneValidQ;
      kGoValidD  = kGoValidQ;
      kDoneStopD = kDoneStopQ;

      // Run length counts every cycle spent starting or running, saturating.
      if ((stateQ == KernelStarting) || (stateQ == KernelRunning)) begin
        if (runQ != '1) runD = runQ + CycleCountWidth'(1);
      end

      case (stateQ)
        ResetTimeout: begin
          countD = countQ + ResetCountSize'(1);
          if (countQ == '1) begin
            stateD     = ResetIdle;
            countD     = '0;
            goHoldoffD = 1'b0;
          end
        end
        ResetIdle: begin
          goHoldoffD = 1'b0;
          if (regGoValid[i] && !goHoldoffQ) begin
            stateD     = KernelStarting;
            kResetD    = 1'b0;
            runD       = '0;
            goHoldoffD = 1'b1;
          end
        end
        KernelStarting: begin
          if (regAbort[i]) begin
            stateD     = ResetTimeout;
            countD     = '0;
            kResetD    = 1'b1;
            kGoValidD  = 1'b0;
            kDoneStopD = 1'b1;
          end else if (kGoValidQ && !kernelGoHoldoff[i]) begin
            stateD     = KernelRunning;
            kGoValidD  = 1'b0;
            kDoneStopD = 1'b0;
          end else begin
            // Go is offered only once the kernel's reset tree has fully drained.
            kGoValidD = (pipeQ == '0);
          end
        end
        KernelRunning: begin
          kDoneStopD = 1'b0;
          if (regAbort[i]) begin
            stateD     = ResetTimeout;
            countD     = '0;
            kResetD    = 1'b1;
            kDoneStopD = 1'b1;
          end else if (kernelDoneValid[i] && !kDoneStopQ) begin
            stateD     = KernelExited;
            kDoneStopD = 1'b1;
            doneValidD = 1'b1;
          end
        end
        KernelExited: begin
          doneValidD = 1'b1;
          if (doneValidQ && !regDoneStop[i]) begin
            stateD     = ResetTimeout;
            countD     = '0;
            kResetD    = 1'b1;
            doneValidD = 1'b0;
          end
        end
        default: begin
          // Illegal encoding: recover exactly as a reset of this channel.
          stateD     = ResetTimeout;
          countD     = '0;
          runD       = '0;
          kResetD    = 1'b1;
          goHoldoffD = 1'b1;
          doneValidD = 1'b0;
          kGoValidD  = 1'b0;
          kDoneStopD = 1'b1;
        end
      endcase
    end

    // Channel state register with synchronous internal reset.
    always_ff @(posedge clk) begin
      if (rstQ) begin
        stateQ     <= ResetTimeout;
        countQ     <= '0;
        runQ       <= '0;
        kResetQ    <= 1'b1;
        goHoldoffQ <= 1'b1;
        doneValidQ <= 1'b0;
        kGoValidQ  <= 1'b0;
        kDoneStopQ <= 1'b1;
      end else begin
        stateQ     <= stateD;
        countQ     <= countD;
        runQ       <= runD;
        kResetQ    <= kResetD;
        goHoldoffQ <= goHoldoffD;
        doneValidQ <= doneValidD;
        kGoValidQ  <= kGoValidD;
        kDoneStopQ <= kDoneStopD;
      end
    end

    // Kernel reset pipeline, sourced by the channel reset or the internal reset.
    always_ff @(posedge clk) begin
      if (rstQ || kResetQ) pipeQ <= '1;
      else                 pipeQ <= pipeQ >> 1;
    end

    assign regGoHoldoff[i]   = goHoldoffQ;
    assign regDoneValid[i]   = doneValidQ;
    assign kernelGoValid[i]  = kGoValidQ;
    assign kernelDoneStop[i] = kDoneStopQ;
    assign kernelReset[i]    = pipeQ[0];
    assign regRunCycles[i*CycleCountWidth +: CycleCountWidth] = runQ;
  end

endmodule

// File: tb/tb_sda_multi_kernel_reset_handler.sv
// Directed bench for the multi-kernel reset handler: a table-driven run on
// channel 3, plus hand-written sequences for timing, backpressure, abort,
// saturation and mid-run system reset.
module tb_sda_multi_kernel_reset_handler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         sysRstReq;
  logic [3:0]   regGoValid, regGoHoldoff, regDoneValid, regDoneStop, regAbort;
  logic [127:0] regRunCycles;
  logic [3:0]   kernelGoValid, kernelGoHoldoff, kernelDoneValid, kernelDoneStop;
  logic         wrapperReset;
  logic [3:0]   kernelReset;

  logic         d1RegGoHoldoff, d1RegDoneValid, d1KernelGoValid, d1KernelDoneStop;
  logic         d1WrapperReset, d1KernelReset;
  logic [3:0]   d1RegRunCycles;

  sda_multi_kernel_reset_handler #(
    .NumKernels(4), .ResetCountSize(5), .ResetPipeLength(8), .CycleCountWidth(32)
  ) dut (
    .clk(clk), .sysRstReq(sysRstReq),
    .regGoValid(regGoValid), .regGoHoldoff(regGoHoldoff),
    .regDoneValid(regDoneValid), .regDoneStop(regDoneStop),
    .regAbort(regAbort), .regRunCycles(regRunCycles),
    .kernelGoValid(kernelGoValid), .kernelGoHoldoff(kernelGoHoldoff),
    .kernelDoneValid(kernelDoneValid), .kernelDoneStop(kernelDoneStop),
    .wrapperReset(wrapperReset), .kernelReset(kernelReset)
  );

  // Narrow-counter instance shadowing channel 0 of the main instance.
  sda_multi_kernel_reset_handler #(
    .NumKernels(1), .ResetCountSize(5), .ResetPipeLength(8), .CycleCountWidth(4)
  ) dutNarrow (
    .clk(clk), .sysRstReq(sysRstReq),
    .regGoValid(regGoValid[0]), .regGoHoldoff(d1RegGoHoldoff),
    .regDoneValid(d1RegDoneValid), .regDoneStop(regDoneStop[0]),
    .regAbort(regAbort[0]), .regRunCycles(d1RegRunCycles),
    .kernelGoValid(d1KernelGoValid), .kernelGoHoldoff(kernelGoHoldoff[0]),
    .kernelDoneValid(kernelDoneValid[0]), .kernelDoneStop(d1KernelDoneStop),
    .wrapperReset(d1WrapperReset), .kernelReset(d1KernelReset)
  );

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  int goXfer[4];
  int doneXfer[4];

  typedef struct {
    int   n;
    logic gv, kgh, kdv, rds, ab;
    logic rgh, kgv, kds, rdv, krst;
    int   rc;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Counts transfers that the coming edge will perform, then advances one cycle.
  task automatic tick();
    for (int c = 0; c < 4; c++) begin
      if (kernelGoValid[c] && !kernelGoHoldoff[c]) goXfer[c]++;
      if (regDoneValid[c] && !regDoneStop[c])      doneXfer[c]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitIdle(input logic [3:0] m);
    int n;
    n = 0;
    while (((regGoHoldoff & m) != 4'b0) && (n < 100)) begin
      tick();
      n++;
    end
    chk("wait_idle", regGoHoldoff & m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tA, tD, snap, n;
    vec_t v;

    for (int c = 0; c < 4; c++) begin goXfer[c] = 0; doneXfer[c] = 0; end
    sysRstReq = 1'b1; regGoValid = '0; regDoneStop = '0; regAbort = '0;
    kernelGoHoldoff = '0; kernelDoneValid = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_goholdoff", regGoHoldoff, 4'hF);
    chk("rst_donevalid", regDoneValid, 4'h0);
    chk("rst_kgovalid", kernelGoValid, 4'h0);
    chk("rst_kdonestop", kernelDoneStop, 4'hF);
    chk("rst_runcycles", regRunCycles == '0, 1);
    chk("rst_wrapper", wrapperReset, 1);
    chk("rst_kreset", kernelReset, 4'hF);
    chk("rst_narrow_run", d1RegRunCycles, 0);

    // Release: wrapper reset drains after 8 shifts, timeout lasts 32 cycles
    sysRstReq = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      tick();
      if (k == 7 || k == 8) chk("pwr_wrapper_reset", wrapperReset, (k < 8) ? 1 : 0);
      if (k == 31 || k == 32) chk("pwr_goholdoff", regGoHoldoff, (k < 32) ? 4'hF : 4'h0);
    end
    chk("pwr_kreset_held", kernelReset, 4'hF);

    // Table-driven run on channel 3: full run, idle return, abort in starting
    tbl[0]  = '{1,  1,0,0,0,0, 1,0,1,0,1, 0};
    tbl[1]  = '{7,  0,0,0,0,0, 1,0,1,0,1, 7};
    tbl[2]  = '{1,  0,0,0,0,0, 1,0,1,0,0, 8};
    tbl[3]  = '{3,  0,1,0,0,0, 1,1,1,0,0, 11};
    tbl[4]  = '{1,  0,0,0,0,0, 1,0,0,0,0, 12};
    tbl[5]  = '{4,  0,0,0,0,0, 1,0,0,0,0, 16};
    tbl[6]  = '{1,  0,0,1,1,0, 1,0,1,1,0, 17};
    tbl[7]  = '{2,  0,0,0,1,0, 1,0,1,1,0, 17};
    tbl[8]  = '{1,  0,0,0,0,0, 1,0,1,0,0, 17};
    tbl[9]  = '{1,  0,0,0,0,0, 1,0,1,0,1, 17};
    tbl[10] = '{30, 0,0,0,0,0, 1,0,1,0,1, 17};
    tbl[11] = '{1,  0,0,0,0,0, 0,0,1,0,1, 17};
    tbl[12] = '{1,  1,0,0,0,0, 1,0,1,0,1, 0};
    tbl[13] = '{1,  0,0,0,0,1, 1,0,1,0,1, 1};
    tbl[14] = '{3,  0,0,0,0,1, 1,0,1,0,1, 1};
    tbl[15] = '{28, 0,0,0,0,0, 1,0,1,0,1, 1};
    tbl[16] = '{1,  0,0,0,0,0, 0,0,1,0,1, 1};
    for (int r = 0; r < 17; r++) begin
      v = tbl[r];
      regGoValid[3] = v.gv; kernelGoHoldoff[3] = v.kgh; kernelDoneValid[3] = v.kdv;
      regDoneStop[3] = v.rds; regAbort[3] = v.ab;
      for (int j = 0; j < v.n; j++) begin
        tick();
        chk($sformatf("tbl%0d_outs", r),
            {regGoHoldoff[3], kernelGoValid[3], kernelDoneStop[3], regDoneValid[3], kernelReset[3]},
            {v.rgh, v.kgv, v.kds, v.rdv, v.krst});
      end
      chk($sformatf("tbl%0d_runcycles", r), regRunCycles[127:96], v.rc);
    end
    regGoValid[3] = 0; kernelGoHoldoff[3] = 0; kernelDoneValid[3] = 0;
    regDoneStop[3] = 0; regAbort[3] = 0;

    // Channel 0 full run with a 100-cycle kernel
    waitIdle(4'b0001);
    regGoValid[0] = 1'b1; tA = cyc + 1; tick(); regGoValid[0] = 1'b0;
    chk("t2_goholdoff", regGoHoldoff[0], 1);
    repeat (7) tick();
    chk("t2_kreset_a7", kernelReset[0], 1);
    tick();
    chk("t2_kreset_a8", kernelReset[0], 0);
    chk("t2_kgo_a8", kernelGoValid[0], 0);
    tick();
    chk("t2_kgo_a9", kernelGoValid[0], 1);
    tick();
    chk("t2_kgo_taken", kernelGoValid[0], 0);
    chk("t2_running_dstop", kernelDoneStop[0], 0);
    repeat (99) tick();
    kernelDoneValid[0] = 1'b1; tD = cyc + 1; tick(); kernelDoneValid[0] = 1'b0;
    chk("t2_regdone", regDoneValid[0], 1);
    chk("t2_runcycles", regRunCycles[31:0], tD - tA);
    chk("t2_runcycles_110", tD - tA, 110);
    tick();
    chk("t2_regdone_clear", regDoneValid[0], 0);
    chk("t2_kreset_at_xfer", kernelReset[0], 0);
    tick();
    chk("t2_kreset_back", kernelReset[0], 1);
    chk("t2_runcycles_frozen", regRunCycles[31:0], 110);
    chk("t5_narrow_saturated", d1RegRunCycles, 4'hF);

    // Channel 1 backpressure on both handshakes
    kernelGoHoldoff[1] = 1'b1;
    waitIdle(4'b0010);
    regGoValid[1] = 1'b1; tick(); regGoValid[1] = 1'b0;
    n = 0;
    while (!kernelGoValid[1] && n < 20) begin tick(); n++; end
    chk("t3_kgo_rise", kernelGoValid[1], 1);
    snap = goXfer[1];
    repeat (20) begin tick(); chk("t3_kgo_hold", kernelGoValid[1], 1); end
    kernelGoHoldoff[1] = 1'b0; tick();
    chk("t3_kgo_drop", kernelGoValid[1], 0);
    tick();
    chk("t3_go_xfers", goXfer[1] - snap, 1);
    regDoneStop[1] = 1'b1; kernelDoneValid[1] = 1'b1; tick(); kernelDoneValid[1] = 1'b0;
    chk("t3_regdone_rise", regDoneValid[1], 1);
    snap = doneXfer[1];
    repeat (15) begin tick(); chk("t3_regdone_hold", regDoneValid[1], 1); end
    regDoneStop[1] = 1'b0; tick();
    chk("t3_regdone_drop", regDoneValid[1], 0);
    chk("t3_done_xfers", doneXfer[1] - snap, 1);

    // Shortest run: 10 starting cycles plus 1 running cycle = 11, below saturation
    waitIdle(4'b0001);
    regGoValid[0] = 1'b1; kernelDoneValid[0] = 1'b1; tick(); regGoValid[0] = 1'b0;
    repeat (11) tick();
    kernelDoneValid[0] = 1'b0;
    chk("t5_short_regdone", regDoneValid[0], 1);
    chk("t5_short_run_w32", regRunCycles[31:0], 11);
    chk("t5_short_run_w4", d1RegRunCycles, 11);
    tick();

    // Abort channel 2 while running, with a same-cycle done
    waitIdle(4'hF);
    regGoValid = 4'hF; tick(); regGoValid = 4'h0;
    repeat (10) tick();
    chk("t4_all_running", kernelDoneStop, 4'h0);
    repeat (5) tick();
    snap = doneXfer[2];
    regAbort[2] = 1'b1; kernelDoneValid[2] = 1'b1; tick();
    regAbort[2] = 1'b0; kernelDoneValid[2] = 1'b0;
    chk("t4_dstop", kernelDoneStop, 4'b0100);
    chk("t4_no_regdone", regDoneValid, 4'h0);
    chk("t4_goholdoff2", regGoHoldoff[2], 1);
    tick();
    chk("t4_kreset", kernelReset, 4'b0100);
    repeat (30) begin tick(); chk("t4_regdone2_low", regDoneValid[2], 0); end
    chk("t4_goholdoff2_b31", regGoHoldoff[2], 1);
    chk("t4_others_running", {kernelDoneStop[3], kernelDoneStop[1], kernelDoneStop[0]}, 3'b000);
    tick();
    chk("t4_goholdoff2_b32", regGoHoldoff[2], 0);
    chk("t4_done2_xfers", doneXfer[2] - snap, 0);
    kernelDoneValid = 4'b1011; tick(); kernelDoneValid = 4'h0;
    chk("t4_others_done", regDoneValid, 4'b1011);
    tick();
    chk("t4_regdone_clear", regDoneValid, 4'h0);

    // System reset pulse while all channels run
    waitIdle(4'hF);
    regGoValid = 4'hF; tick(); regGoValid = 4'h0;
    repeat (12) tick();
    chk("t6_all_running", kernelDoneStop, 4'h0);
    sysRstReq = 1'b1; tick(); sysRstReq = 1'b0; kernelDoneValid = 4'hF;
    tick();
    chk("t6_goholdoff", regGoHoldoff, 4'hF);
    chk("t6_regdone", regDoneValid, 4'h0);
    chk("t6_kgo", kernelGoValid, 4'h0);
    chk("t6_dstop", kernelDoneStop, 4'hF);
    chk("t6_runcycles", regRunCycles == '0, 1);
    chk("t6_wrapper", wrapperReset, 1);
    chk("t6_kreset", kernelReset, 4'hF);
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("t6_no_regdone", regDoneValid, 4'h0);
      if (k == 7 || k == 8) chk("t6_wrapper_drain", wrapperReset, (k < 8) ? 1 : 0);
    end
    chk("t6_goholdoff_31", regGoHoldoff, 4'hF);
    tick();
    chk("t6_goholdoff_32", regGoHoldoff, 4'h0);
    kernelDoneValid = 4'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
